// File: rtl/sram_pupil_search.sv
// Purpose : scan a grayscale frame held in SRAM and report the bounding box, centre and
//           size of the region darker than a runtime threshold (pupil estimate).
// Latency : iStart at cycle 0, first read address at cycle 1, oDone at cycle IMG_W*IMG_H+2.
// Backpressure: none; one SRAM read is issued every cycle of a scan, and iStart is
//           ignored while oBusy=1.
//
// Ports:
//   iCLK, iRST        clock, synchronous active-high reset
//   iStart            one-cycle pulse that begins a scan (accepted only when idle)
//   iThreshold[9:0]   pixel is dark when data[9:0] < iThreshold; sampled at start
//   oBusy             high from the cycle after an accepted start through the oDone cycle
//   oMEM_ADDR[17:0]   SRAM read address; oMEM_OE_N active-low output enable
//   iMEM_DATA[15:0]   SRAM read data, valid one cycle after its address; only [9:0] used
//   oDone             one-cycle pulse, results valid
//   oFound, oPupil_X, oPupil_Y, oDark_Count   results, held until next oDone or reset
//
// Optional feature: define MIN_PIXELS_CHECK_EN to require at least MIN_PIXELS dark
// pixels before oFound is asserted (oDark_Count always reports the true count).
module sram_pupil_search #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int BASE_ADDR  = 0,
    parameter int MIN_PIXELS = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [9:0]  iThreshold,
    output logic        oBusy,
    output logic [17:0] oMEM_ADDR,
    output logic        oMEM_OE_N,
    input  logic [15:0] iMEM_DATA,
    output logic        oDone,
    output logic        oFound,
    output logic [9:0]  oPupil_X,
    output logic [9:0]  oPupil_Y,
    output logic [19:0] oDark_Count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [9:0]  LAST_X    = 10'(IMG_W - 1);
    localparam logic [9:0]  LAST_Y    = 10'(IMG_H - 1);
    localparam logic [17:0] BASE      = 18'(BASE_ADDR);
    localparam logic [19:0] COUNT_MAX = 20'hFFFFF;

    state_t      state;
    logic [9:0]  threshold;
    logic [9:0]  x, y;          // coordinates of the address being issued
    logic [9:0]  xDly, yDly;    // coordinates of the data arriving this cycle
    logic        vldDly;
    logic [9:0]  minX, maxX, minY, maxY;
    logic [19:0] count;

    // Next-state accumulator values including the pixel arriving this cycle. The
    // result registers are loaded from these at the end of DRAIN so that the last
    // pixel is already folded in during the oDone cycle.
    logic        isDark;
    logic [9:0]  nMinX, nMaxX, nMinY, nMaxY;
    logic [19:0] nCount;
    logic        nFound;
    logic [10:0] sumX, sumY;    // one extra bit so min+max never overflows

    always_comb begin
        isDark = vldDly && (iMEM_DATA[9:0] < threshold);
        nMinX  = minX;
        nMaxX  = maxX;
        nMinY  = minY;
        nMaxY  = maxY;
        nCount = count;
        if (isDark) begin
            if (xDly < minX) nMinX = xDly;
            if (xDly > maxX) nMaxX = xDly;
            if (yDly < minY) nMinY = yDly;
            if (yDly > maxY) nMaxY = yDly;
            if (count != COUNT_MAX) nCount = count + 20'd1;
        end
`ifdef MIN_PIXELS_CHECK_EN
        nFound = (nCount >= 20'(MIN_PIXELS));
`else
        nFound = (nCount != 20'd0);
`endif
        sumX = {1'b0, nMinX} + {1'b0, nMaxX};
        sumY = {1'b0, nMinY} + {1'b0, nMaxY};
    end

    // Upper data bits carry no pixel information; in the default build MIN_PIXELS has
    // no effect either. Fold them into a sink so the intent is explicit.
    logic unusedSink;
`ifdef MIN_PIXELS_CHECK_EN
    assign unusedSink = &{1'b0, iMEM_DATA[15:10]};
`else
    assign unusedSink = &{1'b0, iMEM_DATA[15:10], 32'(MIN_PIXELS)};
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oMEM_OE_N   <= 1'b1;
            oMEM_ADDR   <= 18'd0;
            oFound      <= 1'b0;
            oPupil_X    <= 10'd0;
            oPupil_Y    <= 10'd0;
            oDark_Count <= 20'd0;
            threshold   <= 10'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            xDly        <= 10'd0;
            yDly        <= 10'd0;
            vldDly      <= 1'b0;
            minX        <= 10'd1023;
            minY        <= 10'd1023;
            maxX        <= 10'd0;
            maxY        <= 10'd0;
            count       <= 20'd0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        threshold <= iThreshold;
                        x         <= 10'd0;
                        y         <= 10'd0;
                        oMEM_ADDR <= BASE;
                        oMEM_OE_N <= 1'b0;
                        oBusy     <= 1'b1;
                        minX      <= 10'd1023;
                        minY      <= 10'd1023;
                        maxX      <= 10'd0;
                        maxY      <= 10'd0;
                        count     <= 20'd0;
                        state     <= READ;
                    end
                end
                READ: begin
                    // Address counter wraps naturally at 2^18.
                    oMEM_ADDR <= oMEM_ADDR + 18'd1;
                    xDly      <= x;
                    yDly      <= y;
                    vldDly    <= 1'b1;
                    minX      <= nMinX;
                    maxX      <= nMaxX;
                    minY      <= nMinY;
                    maxY      <= nMaxY;
                    count     <= nCount;
                    if (x == LAST_X) begin
                        x <= 10'd0;
                        if (y == LAST_Y) begin
                            oMEM_OE_N <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            y <= y + 10'd1;
                        end
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                DRAIN: begin
                    vldDly      <= 1'b0;
                    minX        <= nMinX;
                    maxX        <= nMaxX;
                    minY        <= nMinY;
                    maxY        <= nMaxY;
                    count       <= nCount;
                    oFound      <= nFound;
                    oPupil_X    <= nFound ? sumX[10:1] : 10'd0;
                    oPupil_Y    <= nFound ? sumY[10:1] : 10'd0;
                    oDark_Count <= nCount;
                    oDone       <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pupil_search.sv
// Purpose : self-checking bench for sram_pupil_search on an 8x4 frame at base 100,
//           with an SRAM model and a frame-level reference computation.
// Latency : the bench expects oDone exactly IMG_W*IMG_H+2 cycles after start.
// Backpressure: not applicable; the SRAM model answers every read one cycle later.
module tb_sram_pupil_search;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int BASE = 100;
    localparam int MINP = 16;
    localparam int NPIX = W * H;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic [9:0]  iThreshold = 10'd0;
    logic        oBusy;
    logic [17:0] oMEM_ADDR;
    logic        oMEM_OE_N;
    logic [15:0] iMEM_DATA;
    logic        oDone;
    logic        oFound;
    logic [9:0]  oPupil_X;
    logic [9:0]  oPupil_Y;
    logic [19:0] oDark_Count;

    sram_pupil_search #(
        .IMG_W     (W),
        .IMG_H     (H),
        .BASE_ADDR (BASE),
        .MIN_PIXELS(MINP)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iStart     (iStart),
        .iThreshold (iThreshold),
        .oBusy      (oBusy),
        .oMEM_ADDR  (oMEM_ADDR),
        .oMEM_OE_N  (oMEM_OE_N),
        .iMEM_DATA  (iMEM_DATA),
        .oDone      (oDone),
        .oFound     (oFound),
        .oPupil_X   (oPupil_X),
        .oPupil_Y   (oPupil_Y),
        .oDark_Count(oDark_Count)
    );

    always #5 iCLK = ~iCLK;

    // SRAM model: synchronous read, data one cycle after the address. Junk when
    // the output enable is off so a design that samples at the wrong time is caught.
    logic [15:0] mem [0:(1<<18)-1];
    always @(posedge iCLK) begin
        if (!oMEM_OE_N) iMEM_DATA <= mem[oMEM_ADDR];
        else            iMEM_DATA <= 16'($urandom);
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input longint obs, input longint exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected results of the scan in progress, and the values that must be held
    // on the result outputs until the next oDone.
    logic        eFound;
    logic [9:0]  eX, eY;
    int          eCnt;
    logic [40:0] hold = '0;

    function automatic logic [40:0] results();
        return {oFound, oPupil_X, oPupil_Y, oDark_Count};
    endfunction

    // Reference: bounding box of all pixels strictly below the threshold.
    task automatic computeModel(input logic [9:0] thr);
        int mnx = 1023, mny = 1023, mxx = 0, mxy = 0;
        logic [15:0] w;
        eCnt = 0;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                w = mem[BASE + yy * W + xx];
                if (int'(w[9:0]) < int'(thr)) begin
                    eCnt++;
                    if (xx < mnx) mnx = xx;
                    if (xx > mxx) mxx = xx;
                    if (yy < mny) mny = yy;
                    if (yy > mxy) mxy = yy;
                end
            end
        end
`ifdef MIN_PIXELS_CHECK_EN
        eFound = (eCnt >= MINP);
`else
        eFound = (eCnt > 0);
`endif
        eX = eFound ? 10'((mnx + mxx) / 2) : 10'd0;
        eY = eFound ? 10'((mny + mxy) / 2) : 10'd0;
    endtask

    task automatic setPix(input int xx, input int yy, input int val);
        mem[BASE + yy * W + xx] = {6'($urandom), 10'(val)};
    endtask

    task automatic fillConst(input int val);
        for (int i = 0; i < NPIX; i++) mem[BASE + i] = {6'($urandom), 10'(val)};
    endtask

    // Mix of extremes (0, 1023) and arbitrary values to hit both threshold boundaries.
    task automatic fillRandom();
        int v;
        for (int i = 0; i < NPIX; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 1023;
                1:       v = 0;
                default: v = int'($urandom_range(0, 1023));
            endcase
            mem[BASE + i] = {6'($urandom), 10'(v)};
        end
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_busy"}, oBusy, 0);
        checkEq({tag, "_done"}, oDone, 0);
        checkEq({tag, "_oe_n"}, oMEM_OE_N, 1);
        checkEq({tag, "_addr"}, oMEM_ADDR, 0);
        checkEq({tag, "_results"}, results(), 0);
    endtask

    // Start a scan and follow it cycle by cycle. retrigAt pulses iStart again at that
    // cycle; abortAt asserts reset at that cycle and ends the scan there.
    task automatic doScan(input logic [9:0] thr, input int retrigAt, input int abortAt);
        int issued  = 0;
        int doneCyc = -1;
        int doneCnt = 0;
        computeModel(thr);
        iThreshold = thr;
        iStart     = 1'b1;
        @(posedge iCLK); #1;
        iStart     = 1'b0;
        iThreshold = 10'($urandom);   // must have been latched at start
        for (int cyc = 1; cyc <= NPIX + 8; cyc++) begin
            if (cyc == abortAt) begin
                iRST = 1'b1;
                @(posedge iCLK); #1;
                iRST = 1'b0;
                checkResetState("abort");
                hold = '0;
                return;
            end
            if (oDone && doneCyc < 0) begin
                doneCyc = cyc;
                checkEq("busy_at_done", oBusy, 1);
                checkEq("found", oFound, eFound);
                checkEq("pupil_x", oPupil_X, eX);
                checkEq("pupil_y", oPupil_Y, eY);
                checkEq("dark_count", oDark_Count, eCnt);
                hold = {eFound, eX, eY, 20'(eCnt)};
            end else if (doneCyc < 0) begin
                checkEq("busy", oBusy, 1);
                checkEq("results_held", results(), hold);
            end else begin
                checkEq("busy_after", oBusy, 0);
                checkEq("extra_done", oDone, 0);
            end
            if (!oMEM_OE_N) begin
                checkEq("addr", oMEM_ADDR, 18'(BASE + issued));
                issued++;
            end
            if (oDone) doneCnt++;
            iStart = (cyc == retrigAt);
            @(posedge iCLK); #1;
        end
        iStart = 1'b0;
        checkEq("done_cycle", doneCyc, NPIX + 2);
        checkEq("done_count", doneCnt, 1);
        checkEq("reads_issued", issued, NPIX);
    endtask

    initial begin
        iMEM_DATA = '0;
        repeat (3) @(posedge iCLK);
        #1;
        checkResetState("reset");
        iRST = 1'b0;
        @(posedge iCLK); #1;

        // Uniform bright frame: nothing dark.
        fillConst(500);
        doScan(10'd100, -1, -1);

        // Four dark corners of a box -> centre (3,2).
        fillConst(500);
        setPix(2, 1, 10); setPix(5, 1, 10); setPix(2, 3, 10); setPix(5, 3, 10);
        doScan(10'd100, -1, -1);

        // Strict comparison at the last pixel of the frame.
        fillConst(500);
        setPix(7, 3, 200);
        doScan(10'd200, -1, -1);
        setPix(7, 3, 199);
        doScan(10'd200, -1, -1);

        // Reset mid-scan, then a clean scan.
        fillRandom();
        doScan(10'($urandom), -1, 10);
        repeat (2) @(posedge iCLK);
        #1;
        doScan(10'd600, -1, -1);

        // Second start during a scan is ignored.
        fillRandom();
        doScan(10'd512, 5, -1);

        // Threshold boundaries.
        fillRandom();
        doScan(10'd0, -1, -1);
        doScan(10'd1023, -1, -1);

        // At least MIN_PIXELS dark pixels.
        fillConst(800);
        for (int i = 0; i < 16; i++) setPix(i % W, 1 + i / W, 3);
        doScan(10'd100, -1, -1);

        // Random frames and thresholds, back-to-back.
        for (int k = 0; k < 6; k++) begin
            fillRandom();
            doScan(10'($urandom), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sram_pupil_search.md
Name: sram_pupil_search

Overview:
- Consumes the grayscale frame already written to external SRAM, one 10-bit pixel per 16-bit word in data[9:0].
- Per start request, scans a rectangular IMG_W x IMG_H frame from BASE_ADDR and classifies each pixel as dark or not against a runtime threshold.
- Reports the bounding box of dark pixels, its centre (pupil estimate) and the dark-pixel count.
- Sits directly downstream of the SRAM writer. It owns the SRAM read port only while oBusy=1.

Parameters:
IMG_W, 320, pixels per line (1..1023)
IMG_H, 240, lines per frame (1..1023)
BASE_ADDR, 0, SRAM word address of pixel (0,0)
MIN_PIXELS, 16, minimum dark count for oFound (used only with the optional feature)

Ports:
iCLK  input  1  system clock
iRST  input  1  synchronous reset, active-high
iStart  input  1  one-cycle pulse; begin a scan
iThreshold  input  10  pixel is dark when data[9:0] < iThreshold (strict); sampled at start
oBusy  output  1  high from the cycle after an accepted start until oDone
oMEM_ADDR  output  18  SRAM read address
oMEM_OE_N  output  1  SRAM output enable, active-low
iMEM_DATA  input  16  SRAM read data, valid one cycle after the address is driven
oDone  output  1  one-cycle pulse; results valid
oFound  output  1  dark region present
oPupil_X  output  10  (min_x+max_x)>>1
oPupil_Y  output  10  (min_y+max_y)>>1
oDark_Count  output  20  number of dark pixels

Behaviour:
- Reset (iRST=1 at a clock edge), including mid-scan:
  - State -> IDLE; oBusy=0, oDone=0, oMEM_OE_N=1, oMEM_ADDR=0.
  - oFound=0, oPupil_X=0, oPupil_Y=0, oDark_Count=0.
  - Any in-flight read is discarded.
- States:
  - IDLE: iStart=1 -> READ. Latch iThreshold, set x=y=0, address=BASE_ADDR, clear accumulators (min_x=min_y=1023, max_x=max_y=0, count=0).
  - READ: each cycle drive oMEM_ADDR=address and oMEM_OE_N=0, then increment address. Coordinates advance raster-order, x wrapping at IMG_W-1 with y++. After issuing (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: one cycle, oMEM_OE_N=1. The last pixel's data is consumed -> DONE.
  - DONE: one cycle. Register results, pulse oDone -> IDLE.
- Address is generated by an incrementing counter (no multiplier); it wraps modulo 2^18.
- Read pipeline: the issue coordinates are delayed one cycle alongside a valid bit. When valid and iMEM_DATA[9:0] < threshold:
  - count++;
  - min/max x,y updated (compare against delayed coords).
  - iMEM_DATA[15:10] is ignored.
- Latency: iStart at cycle 0 -> first address at cycle 1 -> oDone high at cycle IMG_W*IMG_H+2.
- oBusy is high from cycle 1 through the oDone cycle inclusive.
- iStart while oBusy=1 is ignored; no queueing.
- oFound=1 iff count>0 (default build). If oFound=0, oPupil_X/Y=0.
- Results (oFound, oPupil_X/Y, oDark_Count) hold until the next oDone or reset. They do not change during a scan.
- Centre sum is 11 bits wide before the shift, so there is no overflow.
- Threshold 0: nothing is dark. Threshold 1023: every pixel except value 1023 is dark.
- Count saturates at 2^20-1 (unreachable within limits, still required).

Optional Feature:
MIN_PIXELS_CHECK_EN
- Defined: oFound=1 only if count >= MIN_PIXELS. When the check fails, oFound=0 and oPupil_X/Y=0, but oDark_Count still reports the true count.
- Undefined: oFound = (count>0) and MIN_PIXELS is unused.

Test Plan:
- IMG_W=8, IMG_H=4, BASE_ADDR=100, all pixels 500, threshold 100, start:
  - addresses 100..131 issued once each, in order;
  - oDone at cycle 34;
  - oFound=0, oDark_Count=0, X=Y=0.
- Same frame, dark (value 10) at (2,1),(5,1),(2,3),(5,3), threshold 100 -> oFound=1, X=3, Y=2, oDark_Count=4.
- Single dark pixel at (7,3), pixel value equal to threshold 200, then value 199:
  - value 200 -> oFound=0;
  - value 199 -> oFound=1, X=7, Y=3, count=1.
- Reset asserted at cycle 10 of a scan:
  - next cycle oBusy=0, oMEM_OE_N=1, all results 0;
  - a new start then completes normally with correct results.
- iStart pulsed again at cycle 5 of a scan -> ignored; exactly one oDone at cycle 34; address sequence unbroken.
- MIN_PIXELS_CHECK_EN, MIN_PIXELS=16, 4 dark pixels -> oFound=0, oDark_Count=4. With 16 dark pixels -> oFound=1.
